rgb2bayer: RTL and testbench
============================

RGB2BAYER -- requirements
Module: rgb2bayer

Interface
REQ-001 Parameter DISP_WIDTH, default 402, meaning pixels per line (2..1023).
REQ-002 Parameter DISP_HIGHT, default 402, meaning lines per frame (2..1023).
REQ-003 Parameter BAYER_PATTERN, default 0, meaning CFA phase of pixel (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 frame_vsync  input  1  frame sync; rising edge marks frame start.
REQ-007 data_in_valid  input  1  qualifies data_in for one pixel per asserted cycle.
REQ-008 data_in  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
REQ-009 data_out_valid  output  1  qualifies data_out.
REQ-010 data_out  output  8  Bayer raw sample.
REQ-011 frame_vsync_out  output  1  frame_vsync delayed to match data latency.
REQ-012 frame_done  output  1  one-cycle pulse with last pixel of a frame.

Function
REQ-013 Position counters x_cnt, y_cnt (10 bit) SHALL hold the coordinate of the current input pixel, starting at (0,0).
REQ-014 x_cnt SHALL increment only on data_in_valid; at DISP_WIDTH-1 with valid it wraps to 0 and y_cnt increments.
REQ-015 y_cnt SHALL wrap to 0 when x_cnt=DISP_WIDTH-1, y_cnt=DISP_HIGHT-1 and data_in_valid.
REQ-016 Gaps in data_in_valid SHALL hold counters; no pixel is dropped or duplicated.
REQ-017 A frame_vsync rising edge (registered edge detect, vsync_d1) SHALL force x_cnt=0, y_cnt=0 before that cycle's pixel is counted; a valid pixel in the same cycle is pixel (0,0) and counters then advance to (1,0).
REQ-018 Channel select SHALL use phase = {y_cnt[0], x_cnt[0]} XOR'd with BAYER_PATTERN {row-swap, col-swap} bits: phase 00->R, 01/10->G, 11->B.
REQ-019 For RGGB: even row even col R, even row odd col G, odd row even col G, odd row odd col B.
REQ-020 data_out SHALL be the selected 8-bit channel, registered; latency exactly 1 cycle from data_in_valid to data_out_valid.
REQ-021 data_out SHALL hold its last value while data_out_valid=0.
REQ-022 frame_vsync_out SHALL be frame_vsync delayed 1 cycle.
REQ-023 frame_done SHALL pulse high for 1 cycle coincident with data_out_valid of pixel (DISP_WIDTH-1, DISP_HIGHT-1).
REQ-024 Frame_vsync edge mid-frame SHALL abort the frame silently: no frame_done, counters restart at (0,0).
REQ-025 No arithmetic on pixel values; pure selection, no saturation required.

Reset
REQ-026 On rst_n low: x_cnt=0, y_cnt=0, vsync_d1=0, data_out=8'd0, data_out_valid=0, frame_vsync_out=0, frame_done=0, asynchronously.
REQ-027 Reset asserted mid-line SHALL discard the partial frame; first valid pixel after release is (0,0).

Structure
REQ-028 Shared package holds CFA phase constants (PAT_RGGB, PAT_GRBG, PAT_GBRG, PAT_BGGR) and channel-select encoding; shared with bayer2rgb.
REQ-029 One sub-module is natural: bayer_pos_cnt (vsync edge detect, x/y counters, last-pixel flag), reusable by bayer2rgb.

Verification
REQ-030 RGGB, 4x4 frame, data_in={8'hAA,8'h55,8'h11} every pixel -> data_out rows AA,55,AA,55 / 55,11,55,11 repeated, 1-cycle latency.
REQ-031 BGGR, same stimulus -> row 0 = 11,55,11,55; row 1 = 55,AA,55,AA.
REQ-032 Valid toggling 1-0-1-0 through a line -> output sequence identical to continuous case, data_out held during gaps.
REQ-033 DISP_WIDTH=DISP_HIGHT=402, full frame -> exactly 161604 data_out_valid pulses, one frame_done on the last, counters back at (0,0).
REQ-034 vsync rising at pixel (100,7) with valid same cycle -> that pixel emitted as R (RGGB), no frame_done for aborted frame.
REQ-035 rst_n low at pixel (5,3), released -> all outputs 0 during reset, next pixel treated as (0,0).

Source files
------------

// File: rtl/rgb2bayer_pkg.sv
// rgb2bayer_pkg: CFA phase constants and channel-select encoding shared by rgb2bayer and bayer2rgb.
package rgb2bayer_pkg;
  localparam int CNT_W = 10;
  localparam logic [1:0] PAT_RGGB = 2'd0;
  localparam logic [1:0] PAT_GRBG = 2'd1;
  localparam logic [1:0] PAT_GBRG = 2'd2;
  localparam logic [1:0] PAT_BGGR = 2'd3;
  typedef enum logic [1:0] {CH_R = 2'd0, CH_G = 2'd1, CH_B = 2'd2} chan_e;
  // phase is {row parity, col parity} already XOR'd with the pattern's {row-swap, col-swap}
  function automatic chan_e chan_sel(input logic [1:0] phase);
    return phase == 2'b00 ? CH_R : phase == 2'b11 ? CH_B : CH_G;
  endfunction
endpackage

// File: rtl/bayer_pos_cnt.sv
// bayer_pos_cnt: vsync edge detect and x/y pixel position counters; reports the current
// pixel's {row, col} parity and whether it is the last pixel of the frame.
module bayer_pos_cnt
  import rgb2bayer_pkg::*;
#(
  parameter int DISP_WIDTH = 402,
  parameter int DISP_HIGHT = 402
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_vsync,
  input  logic       i_valid,
  output logic [1:0] o_parity,
  output logic       o_last
);
  logic             r_vsync_d1;
  logic [CNT_W-1:0] r_x, r_y;
  logic [CNT_W-1:0] w_x, w_y;
  logic             w_rise, w_x_end, w_y_end;
  // a vsync edge restarts the frame before this cycle's pixel is counted
  assign w_rise   = i_vsync & ~r_vsync_d1;
  assign w_x      = w_rise ? '0 : r_x;
  assign w_y      = w_rise ? '0 : r_y;
  assign w_x_end  = w_x == CNT_W'(DISP_WIDTH - 1);
  assign w_y_end  = w_y == CNT_W'(DISP_HIGHT - 1);
  assign o_parity = {w_y[0], w_x[0]};
  assign o_last   = i_valid & w_x_end & w_y_end;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d1 <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
    end else begin
      r_vsync_d1 <= i_vsync;
      r_x        <= !i_valid ? w_x : w_x_end ? '0 : w_x + 1'b1;
      r_y        <= !(i_valid && w_x_end) ? w_y : w_y_end ? '0 : w_y + 1'b1;
    end
  end
endmodule

// File: rtl/rgb2bayer.sv
// rgb2bayer: converts a 24-bit RGB pixel stream into an 8-bit Bayer mosaic stream
// with one cycle of latency, selecting the channel from the pixel's CFA position.
module rgb2bayer
  import rgb2bayer_pkg::*;
#(
  parameter int DISP_WIDTH    = 402,
  parameter int DISP_HIGHT    = 402,
  parameter int BAYER_PATTERN = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_vsync,
  input  logic        data_in_valid,
  input  logic [23:0] data_in,
  output logic        data_out_valid,
  output logic [7:0]  data_out,
  output logic        frame_vsync_out,
  output logic        frame_done
);
  logic [1:0] w_parity;
  logic       w_last;
  chan_e      w_chan;
  logic [7:0] w_pix;
  logic [7:0] r_data;
  logic       r_valid, r_vsync, r_done;
  bayer_pos_cnt #(
    .DISP_WIDTH(DISP_WIDTH),
    .DISP_HIGHT(DISP_HIGHT)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_vsync (frame_vsync),
    .i_valid (data_in_valid),
    .o_parity(w_parity),
    .o_last  (w_last)
  );
  assign w_chan = chan_sel(w_parity ^ 2'(BAYER_PATTERN));
  assign w_pix  = w_chan == CH_R ? data_in[23:16] : w_chan == CH_B ? data_in[7:0] : data_in[15:8];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_vsync <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= data_in_valid;
      r_vsync <= frame_vsync;
      r_done  <= w_last;
      if (data_in_valid) r_data <= w_pix;
    end
  end
  assign data_out        = r_data;
  assign data_out_valid  = r_valid;
  assign frame_vsync_out = r_vsync;
  assign frame_done      = r_done;
endmodule

// File: tb/tb_rgb2bayer.sv
// tb_rgb2bayer: randomized self-checking bench; an RGGB and a BGGR instance share stimulus
// and are compared against a frame-index reference model.
module tb_rgb2bayer;
  localparam int W = 6;
  localparam int H = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b0;
  logic        v = 1'b0;
  logic [23:0] d = '0;
  logic        ov0, ov1, ovs0, ovs1, od0, od1;
  logic [7:0]  o0, o1;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          idx = 0;
  logic        prev_vs = 1'b0;
  logic [7:0]  held0 = '0, held1 = '0;
  logic [7:0]  e0, e1;
  logic        ev, edn, evs;
  int          exp_done = 0, dn0 = 0, dn1 = 0;
  always #5 clk = ~clk;
  rgb2bayer #(.DISP_WIDTH(W), .DISP_HIGHT(H), .BAYER_PATTERN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_vsync(vs), .data_in_valid(v), .data_in(d),
    .data_out_valid(ov0), .data_out(o0), .frame_vsync_out(ovs0), .frame_done(od0));
  rgb2bayer #(.DISP_WIDTH(W), .DISP_HIGHT(H), .BAYER_PATTERN(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_vsync(vs), .data_in_valid(v), .data_in(d),
    .data_out_valid(ov1), .data_out(o1), .frame_vsync_out(ovs1), .frame_done(od1));

  // channel of linear frame index k for a pattern given as {row-swap, col-swap}
  function automatic logic [7:0] pick(input logic [23:0] di, input int k, input int pat);
    int ph;
    ph = (((k / W) % 2) * 2 + (k % W) % 2) ^ pat;
    return ph == 0 ? di[23:16] : ph == 3 ? di[7:0] : di[15:8];
  endfunction

  task automatic step(input logic vsi, input logic vi, input logic [23:0] di);
    @(negedge clk);
    vs = vsi; v = vi; d = di;
    if (vsi && !prev_vs) idx = 0;
    prev_vs = vsi;
    ev = vi; evs = vsi; edn = 1'b0;
    if (vi) begin
      held0 = pick(di, idx, 0);
      held1 = pick(di, idx, 3);
      edn = (idx == W * H - 1);
      idx = (idx + 1) % (W * H);
    end
    e0 = held0; e1 = held1;
    if (edn) exp_done++;
    @(posedge clk); #1;
    if (od0) dn0++;
    if (od1) dn1++;
  endtask

  task automatic model_reset();
    idx = 0; prev_vs = 1'b0; held0 = '0; held1 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vs = 1'b0; v = 1'b1; d = 24'hABCDEF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({o0, o1, ov0, ov1, od0, od1, ovs0, ovs1} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset: got o0=%h o1=%h v=%b%b done=%b%b vs=%b%b, want all 0", o0, o1, ov0, ov1, od0, od1, ovs0, ovs1);
    end
    @(negedge clk); rst_n = 1'b1; v = 1'b0;
    model_reset();
  endtask

  task automatic test_pattern();
    for (int k = 0; k < W * H + 5; k++) begin
      step(k == 0, 1'b1, 24'hAA5511);
      n_cmp++;
      if ({o0, o1, ov0, ov1, od0, od1, ovs0, ovs1} !== {e0, e1, ev, ev, edn, edn, evs, evs}) begin
        n_fail++;
        $display("FAIL pattern k=%0d: got %h %h v%b%b d%b%b s%b%b, want %h %h v%b d%b s%b", k, o0, o1, ov0, ov1, od0, od1, ovs0, ovs1, e0, e1, ev, edn, evs);
      end
      if (k == 0) begin
        n_cmp++;
        if ({o0, o1} !== 16'hAA11) begin
          n_fail++;
          $display("FAIL pattern_first_pixel: got %h %h, want aa 11", o0, o1);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [23:0] r;
    for (int k = 0; k < 2 * W * H + 2; k++) begin
      r = 24'($urandom);
      step(k == 0 ? 1'b0 : (k == 1), k % 2 == 1, r);
      n_cmp++;
      if ({o0, o1, ov0, ov1, od0, od1, ovs0, ovs1} !== {e0, e1, ev, ev, edn, edn, evs, evs}) begin
        n_fail++;
        $display("FAIL gaps k=%0d: got %h %h v%b%b d%b%b s%b%b, want %h %h v%b d%b s%b", k, o0, o1, ov0, ov1, od0, od1, ovs0, ovs1, e0, e1, ev, edn, evs);
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    exp_done = 0; dn0 = 0; dn1 = 0;
    for (int k = 0; k < 6 * W * H; k++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, 24'($urandom));
      n_cmp++;
      if ({o0, o1, ov0, ov1, od0, od1, ovs0, ovs1} !== {e0, e1, ev, ev, edn, edn, evs, evs}) begin
        n_fail++;
        bad++;
        if (bad < 10) $display("FAIL random k=%0d: got %h %h v%b%b d%b%b s%b%b, want %h %h v%b d%b s%b", k, o0, o1, ov0, ov1, od0, od1, ovs0, ovs1, e0, e1, ev, edn, evs);
      end
    end
    n_cmp++;
    if (dn0 !== exp_done || dn1 !== exp_done) begin
      n_fail++;
      $display("FAIL random_done_count: got %0d/%0d, want %0d", dn0, dn1, exp_done);
    end
  endtask

  task automatic test_vsync_abort();
    logic [23:0] r;
    step(1'b0, 1'b0, 24'h0);
    exp_done = 0; dn0 = 0; dn1 = 0;
    step(1'b1, 1'b1, 24'($urandom));
    for (int k = 1; k < 2 * W + 3; k++) step(1'b0, 1'b1, 24'($urandom));
    r = 24'h123456;
    step(1'b1, 1'b1, r);
    n_cmp++;
    if ({o0, o1, ov0} !== {r[23:16], r[7:0], 1'b1}) begin
      n_fail++;
      $display("FAIL abort_restart_pixel: got %h %h v%b, want %h %h v1", o0, o1, ov0, r[23:16], r[7:0]);
    end
    for (int k = 1; k < W * H; k++) begin
      step(1'b0, 1'b1, 24'($urandom));
      n_cmp++;
      if ({o0, o1, ov0, ov1, od0, od1, ovs0, ovs1} !== {e0, e1, ev, ev, edn, edn, evs, evs}) begin
        n_fail++;
        $display("FAIL abort k=%0d: got %h %h v%b%b d%b%b s%b%b, want %h %h v%b d%b s%b", k, o0, o1, ov0, ov1, od0, od1, ovs0, ovs1, e0, e1, ev, edn, evs);
      end
    end
    n_cmp++;
    if (dn0 !== 1 || dn1 !== 1) begin
      n_fail++;
      $display("FAIL abort_done_count: got %0d/%0d, want 1", dn0, dn1);
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] r;
    step(1'b1, 1'b1, 24'($urandom));
    for (int k = 1; k < 2 * W + 3; k++) step(1'b0, 1'b1, 24'($urandom));
    @(negedge clk);
    rst_n = 1'b0; vs = 1'b0; v = 1'b1;
    #1;
    n_cmp++;
    if ({o0, o1, ov0, ov1, od0, od1, ovs0, ovs1} !== 24'h0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got o0=%h o1=%h v=%b%b, want all 0", o0, o1, ov0, ov1);
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1; v = 1'b0;
    exp_done = 0; dn0 = 0; dn1 = 0;
    r = 24'hC3A55A;
    step(1'b0, 1'b1, r);
    n_cmp++;
    if ({o0, o1} !== {r[23:16], r[7:0]}) begin
      n_fail++;
      $display("FAIL mid_reset_first_pixel: got %h %h, want %h %h", o0, o1, r[23:16], r[7:0]);
    end
    for (int k = 1; k < W * H; k++) begin
      step(1'b0, 1'b1, 24'($urandom));
      n_cmp++;
      if ({o0, o1, ov0, ov1, od0, od1, ovs0, ovs1} !== {e0, e1, ev, ev, edn, edn, evs, evs}) begin
        n_fail++;
        $display("FAIL mid_reset k=%0d: got %h %h v%b%b d%b%b s%b%b, want %h %h v%b d%b s%b", k, o0, o1, ov0, ov1, od0, od1, ovs0, ovs1, e0, e1, ev, edn, evs);
      end
    end
    n_cmp++;
    if (dn0 !== 1 || dn1 !== 1) begin
      n_fail++;
      $display("FAIL mid_reset_done_count: got %0d/%0d, want 1", dn0, dn1);
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_gaps();
    test_random();
    test_vsync_abort();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
